// File: rtl/mbgd_batch_seq_pkg.sv
// Shared types and constants for the MBGD mini-batch sequencer.
// No logic, so no latency.
// No handshakes; only widths, the state encoding and the pipeline tag format.
package mbgd_pkg;

  localparam int unsigned DW        = 8;          // hypothesis / sample element width
  localparam int unsigned BATCH_MAX = 16;         // largest mini-batch
  localparam int unsigned ADDR_W    = 4;          // log2(BATCH_MAX)
  localparam int unsigned N         = ADDR_W;     // short alias used by datapath code
  localparam int unsigned PIPE_LAT  = 3;          // enabled cycles from sample in to h out
  localparam int unsigned CNT_W     = ADDR_W + 1; // counters reach BATCH_MAX without wrapping

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One tag travels alongside each datapath slot; bubbles carry valid=0.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] idx;
  } tag_t;

  // Requested batch length limited to what the sample register file holds.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
    logic [CNT_W-1:0] w_max;
    w_max = CNT_W'(BATCH_MAX);
    return (len > w_max) ? w_max : len;
  endfunction

endpackage

// File: rtl/mbgd_batch_seq_if.sv
// Bundle of control, sample-address and hypothesis handshake signals.
// Pure wiring, no latency.
// h_valid/h_ready is the only back-pressured channel; everything else is level.
interface mbgd_batch_seq_if;

  logic                          start;
  logic [mbgd_pkg::ADDR_W:0]     batch_len;
  logic                          abort;
  logic [mbgd_pkg::ADDR_W-1:0]   smp_addr;
  logic                          dp_enable;
  logic                          teta_lock;
  logic [mbgd_pkg::DW-1:0]       h_in;
  logic                          h_valid;
  logic                          h_ready;
  logic [mbgd_pkg::DW-1:0]       h_out;
  logic [mbgd_pkg::ADDR_W-1:0]   h_idx;
  logic                          busy;
  logic                          done;

  // Sequencer side.
  modport master (
    input  start, batch_len, abort, h_in, h_ready,
    output smp_addr, dp_enable, teta_lock, h_valid, h_out, h_idx, busy, done
  );

  // Controller / datapath / downstream side.
  modport slave (
    output start, batch_len, abort, h_in, h_ready,
    input  smp_addr, dp_enable, teta_lock, h_valid, h_out, h_idx, busy, done
  );

endinterface

// File: rtl/mbgd_batch_seq_tag_pipe.sv
// Tag shift register mirroring the datapath stages (valid + sample index).
// DEPTH enabled cycles from i_tag to o_tag.
// Shifts only while i_en is high, so it stalls in lock-step with the datapath.
module mbgd_tag_pipe
  import mbgd_pkg::*;
#(
  parameter int unsigned DEPTH = PIPE_LAT
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_en,
  input  logic i_clr,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_stage [DEPTH];

  // Shift on enable; synchronous clear drops every in-flight tag at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
    end else if (i_en) begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mbgd_batch_seq.sv
// Mini-batch sequencer: walks samples, drives datapath enable, tags each h with its index.
// Sample k's h is valid PIPE_LAT enabled cycles after it is addressed; done one cycle after the last h.
// h_valid & !h_ready freezes the whole datapath (dp_enable low); nothing is dropped or duplicated.
module mbgd_batch_seq
  import mbgd_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  mbgd_batch_seq_if.master bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_out_cnt;

  logic [CNT_W-1:0] w_len_req;
  logic [CNT_W-1:0] w_len_last;
  logic             w_accept;
  logic             w_busy;
  logic             w_stall;
  logic             w_enable;
  logic             w_hs;
  logic             w_last_issue;
  logic             w_last_out;
  tag_t             w_tag_in;
  tag_t             w_tag_out;

  assign w_len_req  = clamp_len(bus.batch_len);
  assign w_len_last = r_len - CNT_W'(1);
  assign w_accept   = (r_state == S_IDLE) && bus.start && !bus.abort;

  assign w_busy   = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_stall  = w_tag_out.valid && !bus.h_ready;
  assign w_enable = w_busy && !w_stall;
  assign w_hs     = w_tag_out.valid && bus.h_ready;

  // The last sample leaves RUN in the cycle it is actually pushed into the pipe.
  assign w_last_issue = (r_state == S_RUN) && w_enable && (r_issue_cnt == w_len_last);
  // Only the final accepted h can close the batch; earlier samples drain beforehand.
  assign w_last_out   = (r_state == S_DRAIN) && w_hs && (r_out_cnt == w_len_last);

  // RUN feeds real samples, DRAIN feeds bubbles so the tail reaches the output.
  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = (r_state == S_RUN);
    w_tag_in.idx   = (r_state == S_RUN) ? r_issue_cnt[ADDR_W-1:0] : '0;
  end

  mbgd_tag_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .resetn (resetn),
    .i_en   (w_enable),
    .i_clr  (bus.abort),
    .i_tag  (w_tag_in),
    .o_tag  (w_tag_out)
  );

  // Next-state: abort wins everywhere, start only counts in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = (w_len_req == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (bus.abort)         w_state_nxt = S_IDLE;
        else if (w_last_issue) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.abort)       w_state_nxt = S_IDLE;
        else if (w_last_out) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Batch length latch plus issue/output counters; length is frozen after acceptance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_out_cnt   <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        r_len       <= w_len_req;
        r_issue_cnt <= '0;
        r_out_cnt   <= '0;
      end
    end else if (bus.abort) begin
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_out_cnt   <= '0;
    end else begin
      // The index stops at len-1 so smp_addr keeps pointing at the last sample in DRAIN.
      if ((r_state == S_RUN) && w_enable && !w_last_issue)
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      if (w_hs)
        r_out_cnt <= r_out_cnt + CNT_W'(1);
    end
  end

  assign bus.smp_addr  = w_busy ? r_issue_cnt[ADDR_W-1:0] : '0;
  assign bus.dp_enable = w_enable;
  assign bus.teta_lock = w_busy;
  assign bus.busy      = w_busy;
  assign bus.done      = (r_state == S_DONE);
  assign bus.h_valid   = w_tag_out.valid;
  assign bus.h_idx     = w_tag_out.valid ? w_tag_out.idx : '0;
  assign bus.h_out     = w_tag_out.valid ? bus.h_in : '0;

endmodule

// File: doc/mbgd_batch_seq.md
# mbgd_batch_seq

Mini-batch sequencer for the MBGD forward datapath (dot product → adder tree → sigmoid LUT, one shared `enable`). On `start` it walks a mini-batch of samples held in the sample register file and drives the datapath `enable`. It tracks each sample through the fixed-latency pipeline and presents every hypothesis `h` with its sample index to the downstream error/gradient stage over a valid/ready handshake. Back-pressure from that stage stalls the whole datapath by deasserting `enable`.

## Interface
- DW, 8, hypothesis/sample element width
- BATCH_MAX, 16, largest mini-batch
- ADDR_W, 4, sample address width, log2(BATCH_MAX)
- PIPE_LAT, 3, datapath latency in enabled cycles, sample in → h out
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  begin a batch; sampled only in IDLE
- batch_len  in  ADDR_W+1  samples in batch; 0 → empty batch; >BATCH_MAX clamped to BATCH_MAX
- abort  in  1  cancel current batch
- smp_addr  out  ADDR_W  sample register-file read address; read is asynchronous, x valid same cycle
- dp_enable  out  1  datapath `enable`
- teta_lock  out  1  high while busy; teta must not change
- h_in  in  DW  datapath sigmoid output
- h_valid  out  1  h_out/h_idx valid
- h_ready  in  1  downstream accepts
- h_out  out  DW  hypothesis, registered copy of h_in path
- h_idx  out  ADDR_W  sample index of h_out
- busy  out  1  RUN or DRAIN
- done  out  1  one-cycle pulse, batch complete

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start & !abort → latch len = clamp(batch_len), clear issue_cnt/out_cnt. If len==0 → DONE, else → RUN.
- stall = h_valid & !h_ready; dp_enable = (RUN|DRAIN) & !stall.
- RUN: smp_addr = issue_cnt. On each dp_enable cycle, push {valid=1, idx=issue_cnt} into the tag pipe and increment issue_cnt. When issue_cnt reaches len-1 and that sample is issued → DRAIN.
- DRAIN: smp_addr holds the last value. Push {valid=0} bubbles on each enable.
- The tag pipe is PIPE_LAT stages and advances only when dp_enable is high, staying aligned with the datapath registers.
- h_valid = last-stage valid bit; h_idx = last-stage idx; h_out = h_in.
- Each h_valid & h_ready increments out_cnt. In DRAIN, the handshake with out_cnt == len-1 → DONE.
- DONE: done=1, busy=0, teta_lock=0 → IDLE next cycle.
- abort in RUN/DRAIN/DONE → IDLE next edge. Tag pipe and counters are cleared. No done pulse; any h_valid in flight drops.
- abort overrides start in the same cycle.
- start outside IDLE is ignored.
- batch_len changes after acceptance are ignored.
- Counters are wide enough for BATCH_MAX with no wrap. The index never exceeds len-1.

## Timing
- Reset: state IDLE, all outputs 0, tag pipe cleared.
- Start seen at edge 0 → RUN in cycle 1, smp_addr=0, dp_enable=1.
- With h_ready held high, sample k gives h_valid in cycle 1+k+PIPE_LAT.
- The last h appears in cycle len+PIPE_LAT. done pulses in cycle len+PIPE_LAT+1. busy is high for cycles 1..len+PIPE_LAT.
- Each cycle of h_ready low while h_valid stretches all of these by one. h_out, h_idx and smp_addr hold during the stall.
- Empty batch: done in cycle 1, h_valid never asserts.
- A new start is accepted the cycle after DONE (IDLE).

## Structure
- Package `mbgd_pkg`:
  - state enum
  - DW, N, PIPE_LAT, BATCH_MAX constants
  - tag struct {valid, idx}
- Sub-module `mbgd_tag_pipe`: PIPE_LAT-deep shift register of tags with enable and synchronous clear (used by abort), async reset.
- FSM and counters stay in the top.

## Test plan
- len=4, h_ready=1: smp_addr 0,1,2,3 in cycles 1–4. h_valid cycles 4–7 with h_idx 0..3. done in cycle 8, single pulse.
- len=4, h_ready low in cycles 5–6: dp_enable low in those cycles. h_idx=1 held for 3 cycles. done moves to cycle 10. No index is lost or duplicated.
- len=0: done in cycle 1, h_valid never high. batch_len=31: exactly 16 outputs, idx 0..15.
- abort in cycle 3 of a len=8 batch: IDLE next cycle, no done, outputs 0. An immediate restart with len=2 produces idx 0,1 only.
- start pulsed in RUN, plus start and abort in the same IDLE cycle: both are ignored, and the state stays as before.
- resetn asserted in DRAIN: all outputs 0 asynchronously. After release, the block is in IDLE and the next start behaves as in scenario 1.
